// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream logic: controller states,
// prefetch depth and the index/count width helpers.
package fifo_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam int unsigned PREFETCH_DEPTH = 2;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned PREFETCH_IDX_W = idx_width(PREFETCH_DEPTH);
  localparam int unsigned PREFETCH_CNT_W = $clog2(PREFETCH_DEPTH + 1);

endpackage

// File: rtl/stream_skid_buf.sv
// Small circular buffer with push/pop/clear and an occupancy count; the head
// entry is presented combinationally. Reusable on either side of the FIFO.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = PREFETCH_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic [DATA_WIDTH-1:0]         head_data
);

  localparam int unsigned IDX_W = idx_width(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [IDX_W-1:0]      r_head;
  logic [IDX_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;
  logic                  w_pop_ok;

  function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + 1'b1;
  endfunction

  assign w_pop_ok = pop & (r_count != '0);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the storage is reset too: the head entry drives the stream data
  // output, which must read zero out of reset, and there are only DEPTH words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_mem[r_tail] <= push_data;
        r_tail        <= nxt(r_tail);
      end
      if (w_pop_ok) r_head <= nxt(r_head);
      if (push && !w_pop_ok)      r_count <= r_count + 1'b1;
      else if (!push && w_pop_ok) r_count <= r_count - 1'b1;
    end
  end

  assign count     = r_count;
  assign head_data = r_mem[r_head];

  // The producer's credit check must never let a push land in a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !clear && !w_pop_ok && (r_count == CNT_W'(DEPTH))));

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-domain drain engine: turns the FIFO rd_en/empty/dout port into a
// valid/ready stream with a 2-entry prefetch, plus a discard-all flush mode.
// Define FIFO_STREAM_READER_STATS_EN to add word_cnt/stall_cnt counters.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
`ifdef FIFO_STREAM_READER_STATS_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  busy
`ifdef FIFO_STREAM_READER_STATS_EN
  , output logic [CNT_WIDTH-1:0] word_cnt,
  output logic [CNT_WIDTH-1:0]   stall_cnt
`endif
);

  localparam int unsigned OCC_W = PREFETCH_CNT_W + 1;

  state_e                  r_state;
  logic                    r_inflight;
  logic                    r_flush_done;
  logic [PREFETCH_CNT_W-1:0] w_count;
  logic [DATA_WIDTH-1:0]   w_head;
  logic [OCC_W-1:0]        w_occupancy;
  logic                    w_pop;
  logic                    w_room;
  logic                    w_rd_req;
  logic                    w_clear;
  logic                    w_flush_exit;

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (PREFETCH_DEPTH)
  ) u_buf (
    .clk       (rd_clk),
    .rst_n     (rst_n),
    .clear     (w_clear),
    .push      (r_inflight),
    .push_data (fifo_dout),
    .pop       (w_pop),
    .count     (w_count),
    .head_data (w_head)
  );

  assign m_valid = (w_count != '0);
  assign m_data  = w_head;
  assign w_pop   = m_valid & m_ready;

  // Credit counts the slot freed by this cycle's pop so a full buffer can
  // still stream at one word per cycle.
  assign w_occupancy = OCC_W'(w_count) + OCC_W'(r_inflight);
  assign w_room      = w_occupancy < (OCC_W'(PREFETCH_DEPTH) + OCC_W'(w_pop));
  assign w_rd_req    = (r_state == FLUSH) ? !fifo_empty : (!fifo_empty & w_room);

  // Gated by rst_n so no read reaches the FIFO while this block is held in reset.
  assign fifo_rd_en  = rst_n & w_rd_req;

  assign w_clear      = (r_state == FLUSH) | flush;
  assign w_flush_exit = (r_state == FLUSH) & fifo_empty & !r_inflight;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_inflight   <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_inflight   <= w_rd_req;
      r_flush_done <= w_flush_exit;
      if (r_state == RUN) begin
        if (flush) r_state <= FLUSH;
      end else if (w_flush_exit) begin
        r_state <= RUN;
      end
    end
  end

  assign flush_done = r_flush_done;
  assign busy       = (r_state == FLUSH) | m_valid | r_inflight;

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [CNT_WIDTH-1:0] r_word_cnt;
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_pop && (r_word_cnt != '1))                   r_word_cnt  <= r_word_cnt + 1'b1;
      if (m_valid && !m_ready && (r_stall_cnt != '1))    r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign word_cnt  = r_word_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule
